// File: rtl/csa_seq_pkg.sv
// Shared constants for the wide sequential carry-select adder.
// FSM state codes and default slice geometry.
package csa_seq_pkg;

    localparam int SLICE_W_DEF    = 30;
    localparam int NUM_SLICES_DEF = 4;
    localparam int WIDE_DEF       = SLICE_W_DEF * NUM_SLICES_DEF;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/csa_wide_add_seq_slice_cin.sv
// One carry-select adder slice with a carry-in incrementer.
// Purely combinational; cout = adder carry OR increment overflow.
module csa_slice_cin
    import csa_seq_pkg::*;
#(
    parameter int W = SLICE_W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int LO = W / 2;
    localparam int HI = W - LO;

    logic [LO:0]  lo;
    logic [HI:0]  hi0;
    logic [HI:0]  hi1;
    logic [W-1:0] csa_sum;
    logic         csa_cout;
    logic [W:0]   inc;

    assign lo  = {1'b0, a[LO-1:0]} + {1'b0, b[LO-1:0]};
    assign hi0 = {1'b0, a[W-1:LO]} + {1'b0, b[W-1:LO]};
    assign hi1 = {1'b0, a[W-1:LO]} + {1'b0, b[W-1:LO]}
               + {{HI{1'b0}}, 1'b1};

    assign csa_sum  = {lo[LO] ? hi1[HI-1:0] : hi0[HI-1:0],
                       lo[LO-1:0]};
    assign csa_cout = lo[LO] ? hi1[HI] : hi0[HI];

    // a+b <= 2^(W+1)-2, so an all-ones sum never coexists with csa_cout
    assign inc  = {1'b0, csa_sum} + {{W{1'b0}}, cin};
    assign sum  = inc[W-1:0];
    assign cout = csa_cout | inc[W];

endmodule

// File: rtl/csa_wide_add_seq.sv
// Wide adder sequencing one carry-select slice over NUM_SLICES cycles.
// Optional signed overflow flag: define CSA_SEQ_OVF_EN.
module csa_wide_add_seq
    import csa_seq_pkg::*;
#(
    parameter int SLICE_W    = SLICE_W_DEF,
    parameter int NUM_SLICES = NUM_SLICES_DEF,
    parameter int WIDE       = SLICE_W * NUM_SLICES
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [WIDE-1:0] i_add_term1,
    input  logic [WIDE-1:0] i_add_term2,
    input  logic            i_cin,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [WIDE-1:0] o_sum,
    output logic            o_cout,
    output logic            o_ovf,
    output logic            o_busy
);

    localparam int IDX_W = idx_w(NUM_SLICES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SLICES - 1);

    logic [1:0]         state;
    logic [WIDE-1:0]    a_q;
    logic [WIDE-1:0]    b_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx;
    logic [SLICE_W-1:0] s_a;
    logic [SLICE_W-1:0] s_b;
    logic [SLICE_W-1:0] s_sum;
    logic               s_cout;
    logic               accept;
    logic               last_run;

    assign o_ready  = (state == IDLE);
    assign o_valid  = (state == DONE);
    assign o_busy   = (state != IDLE);
    assign accept   = o_ready && i_valid;
    assign last_run = (state == RUN) && (idx == LAST);

    assign s_a = a_q[idx*SLICE_W +: SLICE_W];
    assign s_b = b_q[idx*SLICE_W +: SLICE_W];

    csa_slice_cin #(.W(SLICE_W)) u_slice (
        .a    (s_a),
        .b    (s_b),
        .cin  (carry_q),
        .sum  (s_sum),
        .cout (s_cout)
    );

    // FSM, operand capture and per-slice result write-back
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            o_sum   <= '0;
            o_cout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_q     <= i_add_term1;
                        b_q     <= i_add_term2;
                        carry_q <= i_cin;
                        idx     <= '0;
                        o_sum   <= '0;
                        o_cout  <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    o_sum[idx*SLICE_W +: SLICE_W] <= s_sum;
                    carry_q <= s_cout;
                    if (idx == LAST) begin
                        o_cout <= s_cout;
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (i_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CSA_SEQ_OVF_EN
    // Signed overflow from captured MSBs and the final slice result
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_ovf <= 1'b0;
        end else if (accept) begin
            o_ovf <= 1'b0;
        end else if (last_run) begin
            o_ovf <= (a_q[WIDE-1] == b_q[WIDE-1])
                  && (s_sum[SLICE_W-1] != a_q[WIDE-1]);
        end
    end
`else
    assign o_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_csa_wide_add_seq.sv
// Scoreboard bench for csa_wide_add_seq: directed vectors,
// expected results queued at issue, checked by a monitor.
module tb_csa_wide_add_seq;

    localparam int W = 120;

`ifdef CSA_SEQ_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_sum;
    logic         o_cout;
    logic         o_ovf;
    logic         o_busy;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    csa_wide_add_seq dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_add_term1 (a),
        .i_add_term2 (b),
        .i_cin       (cin),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_sum       (o_sum),
        .o_cout      (o_cout),
        .o_ovf       (o_ovf),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: pop and compare on every accepted result
    always @(negedge clk) begin
        if (!rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got sum %h", o_sum);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sum", o_sum, e.sum);
                chk("cout", W'(o_cout), W'(e.cout));
                chk("ovf", W'(o_ovf), W'(e.ovf));
            end
        end
    end

    task automatic start_op(input logic [W-1:0] ta,
                            input logic [W-1:0] tb,
                            input logic tc, input logic push,
                            input logic [W-1:0] es,
                            input logic ec, input logic eo);
        int n;
        exp_t e;
        n = 0;
        while (!o_ready && n < 30) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_before_op", W'(o_ready), W'(1'b1));
        a = ta; b = tb; cin = tc; i_valid = 1'b1;
        if (push) begin
            e.sum = es; e.cout = ec; e.ovf = eo;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
        a = '0; b = '0; cin = 1'b0;
    endtask

    task automatic wait_valid(input logic chk_busy);
        int lat;
        lat = 0;
        while (!o_valid && lat < 20) begin
            if (chk_busy) chk("busy_run", W'(o_busy), W'(1'b1));
            @(posedge clk); #1; lat++;
        end
        chk("latency", W'(lat), W'(4));
    endtask

    task automatic run_op(input logic [W-1:0] ta,
                          input logic [W-1:0] tb, input logic tc,
                          input logic [W-1:0] es,
                          input logic ec, input logic eo);
        start_op(ta, tb, tc, 1'b1, es, ec, eo);
        wait_valid(1'b0);
        @(posedge clk); #1;
        chk("idle_after", W'(o_ready), W'(1'b1));
    endtask

    initial begin
        logic [W-1:0] held;
        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", W'(o_ready), W'(1'b1));
        chk("rst_valid", W'(o_valid), W'(1'b0));
        chk("rst_busy", W'(o_busy), W'(1'b0));
        chk("rst_sum", o_sum, '0);
        chk("rst_cout", W'(o_cout), W'(1'b0));
        chk("rst_ovf", W'(o_ovf), W'(1'b0));
        rst = 1'b0;
        @(posedge clk); #1;

        // 1 + 2, with busy check through RUN
        start_op(W'(1), W'(2), 1'b0, 1'b1, W'(3), 1'b0, 1'b0);
        wait_valid(1'b1);
        @(posedge clk); #1;

        // inter-slice carry: (2^30-1) + 1 = 2^30
        run_op(W'(30'h3FFF_FFFF), W'(1), 1'b0,
               W'(1) << 30, 1'b0, 1'b0);

        // all ones + 0 + cin ripples through every slice
        run_op({W{1'b1}}, '0, 1'b1, '0, 1'b1, 1'b0);

        // 0x7F..F + 1 -> 0x80..0, signed overflow when enabled
        run_op({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0,
               {1'b1, {(W-1){1'b0}}}, 1'b0, OVF_ON);

        // plain cin into a mid-size sum
        run_op(W'(123), W'(456), 1'b1, W'(580), 1'b0, 1'b0);

        // stall in DONE with new requests ignored
        i_ready = 1'b0;
        start_op(W'(1000), W'(2000), 1'b0, 1'b1,
                 W'(3000), 1'b0, 1'b0);
        wait_valid(1'b0);
        held = o_sum;
        for (int i = 0; i < 10; i++) begin
            i_valid = i[0];
            a = W'(i + 77); b = W'(i * 3); cin = 1'b1;
            @(posedge clk); #1;
            chk("stall_valid", W'(o_valid), W'(1'b1));
            chk("stall_ready", W'(o_ready), W'(1'b0));
            chk("stall_sum", o_sum, held);
        end
        i_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        i_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release", W'(o_ready), W'(1'b1));

        // reset just after accept discards the operation
        start_op(W'(5), W'(7), 1'b0, 1'b0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_sum", o_sum, '0);
        chk("abort_valid", W'(o_valid), W'(1'b0));
        chk("abort_ready", W'(o_ready), W'(1'b1));
        chk("abort_busy", W'(o_busy), W'(1'b0));
        chk("abort_cout", W'(o_cout), W'(1'b0));
        repeat (8) begin
            @(posedge clk); #1;
            chk("abort_no_valid", W'(o_valid), W'(1'b0));
        end

        // recovery after abort
        run_op(W'(10), W'(20), 1'b1, W'(31), 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        chk("queue_drained", W'(exp_q.size()), W'(0));
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
